// File: rtl/face_shader.sv
// face_shader: three-stage clamp / multiply / output shading pipeline.
// Define FACE_SHADER_CULL_STATS_EN to build the saturating cull counter.
module face_shader #(
    parameter int NORM_WIDTH = 16,
    parameter int NORM_FRAC = 14,
    parameter logic [NORM_WIDTH-1:0] AMBIENT = 16'h0800
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic signed [NORM_WIDTH-1:0] intensity_in,
    input  logic                         front_in,
    input  logic [15:0]                  base_color_in,
    input  logic [15:0]                  tri_id_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    output logic [15:0]                  color_out,
    output logic [15:0]                  tri_id_out,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic [31:0]                  cull_count_out
);

    localparam int PW = NORM_WIDTH + 6;
    localparam logic signed [NORM_WIDTH-1:0] ONE =
        $signed(NORM_WIDTH'(1 << NORM_FRAC));

    typedef struct packed {
        logic [NORM_WIDTH-1:0] eff;
        logic [15:0]           color;
        logic [15:0]           tag;
    } s1_t;

    typedef struct packed {
        logic [15:0] color;
        logic [15:0] tag;
    } s2_t;

    logic                  en;
    logic                  accept;
    logic [NORM_WIDTH-1:0] clamped;
    logic [NORM_WIDTH-1:0] eff;
    logic                  s1_valid;
    s1_t                   s1;
    logic                  s2_valid;
    s2_t                   s2;
    logic [PW-1:0]         prod_r;
    logic [PW-1:0]         prod_g;
    logic [PW-1:0]         prod_b;
    logic [15:0]           shaded;

    // A full S3 that is not being drained freezes every stage at once
    assign en        = !valid_out || ready_in;
    assign ready_out = en;
    assign accept    = valid_in && en;

    always_comb begin
        clamped = intensity_in;
        if (intensity_in[NORM_WIDTH-1]) begin
            clamped = '0;
        end else if (intensity_in > ONE) begin
            clamped = ONE;
        end
        eff = (clamped < AMBIENT) ? AMBIENT : clamped;
    end

    always_comb begin
        prod_r = PW'(s1.color[15:11]) * PW'(s1.eff);
        prod_g = PW'(s1.color[10:5]) * PW'(s1.eff);
        prod_b = PW'(s1.color[4:0]) * PW'(s1.eff);
        shaded = {5'(prod_r >> NORM_FRAC),
                  6'(prod_g >> NORM_FRAC),
                  5'(prod_b >> NORM_FRAC)};
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (en) begin
            s1_valid <= valid_in && front_in;
            s1.eff   <= eff;
            s1.color <= base_color_in;
            s1.tag   <= tri_id_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s2_valid <= 1'b0;
            s2       <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2.color <= shaded;
            s2.tag   <= s1.tag;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_out  <= 1'b0;
            color_out  <= '0;
            tri_id_out <= '0;
        end else if (en) begin
            valid_out  <= s2_valid;
            color_out  <= s2.color;
            tri_id_out <= s2.tag;
        end
    end

`ifdef FACE_SHADER_CULL_STATS_EN
    logic [31:0] cull_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cull_q <= '0;
        end else if (accept && !front_in && cull_q != 32'hFFFF_FFFF) begin
            cull_q <= cull_q + 32'd1;
        end
    end

    assign cull_count_out = cull_q;
`else
    logic unused_accept;
    assign unused_accept  = accept;
    assign cull_count_out = '0;
`endif

endmodule
